// File: rtl/lcd_pkg.sv
// Definitions shared by the FIFO write-side blocks: arbiter state encoding,
// default word width and an index-width helper.
package lcd_pkg;

    localparam int LCD_WIDTH = 8;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    // Bits needed to index n requesters; never narrower than one bit.
    function automatic int arb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requester with req set, searching
// upward from the one after rr_last_i and wrapping modulo NREQ.
module rr_pick
    import lcd_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDXW = arb_idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] rr_last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDXW-1:0] idx_o,
    output logic            vld_o
);

    logic [IDXW-1:0] cand;
    logic            found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        // rr_last itself is visited last, so the previous owner has lowest priority.
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDXW'((int'(rr_last_i) + k) % NREQ);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
        vld_o = found;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the FIFO write port among NREQ requesters with packet-granular
// round-robin arbitration and a burst-length watchdog.
module fifo_wr_arbiter
    import lcd_pkg::*;
#(
    parameter int WIDTH     = LCD_WIDTH,
    parameter int NREQ      = 2,
    parameter int MAX_BURST = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       grant,
    input  logic                  fifo_full,
    output logic                  fifo_write_en,
    output logic [WIDTH-1:0]      fifo_write_data,
    output logic                  busy,
    output logic                  burst_err
);

    localparam int IDXW = arb_idx_w(NREQ);
    localparam int CW   = $clog2(MAX_BURST + 1);

    arb_state_e               state_q;
    logic [NREQ-1:0]          grant_q;
    logic [IDXW-1:0]          owner_q;
    logic [IDXW-1:0]          rr_last_q;
    logic [CW-1:0]            cnt_q;
    logic [CW-1:0]            cnt_d;
    logic                     busy_q;
    logic                     burst_err_q;

    logic [NREQ-1:0]          pick_gnt;
    logic [IDXW-1:0]          pick_idx;
    logic                     pick_vld;

    logic [NREQ-1:0][WIDTH-1:0] data_arr;
    logic                     owner_req;
    logic                     owner_last;
    logic                     xfer;
    logic                     hit_max;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req_i     (req),
        .rr_last_i (rr_last_q),
        .gnt_o     (pick_gnt),
        .idx_o     (pick_idx),
        .vld_o     (pick_vld)
    );

    assign data_arr   = req_data;
    assign owner_req  = req[owner_q];
    assign owner_last = req_last[owner_q];

    // Reset gates the strobe so a half-written packet cannot grow during reset.
    assign xfer    = (state_q == ARB_BURST) && owner_req && !fifo_full && !rst;
    assign cnt_d   = cnt_q + CW'(1);
    assign hit_max = (cnt_d == CW'(MAX_BURST));

    assign fifo_write_en   = xfer;
    assign fifo_write_data = data_arr[owner_q];
    assign ack             = xfer ? grant_q : '0;
    assign grant           = grant_q;
    assign busy            = busy_q;
    assign burst_err       = burst_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            rr_last_q   <= IDXW'(NREQ - 1);
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            burst_err_q <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_vld) begin
                        state_q <= ARB_BURST;
                        grant_q <= pick_gnt;
                        owner_q <= pick_idx;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ARB_BURST: begin
                    if (xfer) begin
                        if (owner_last || hit_max) begin
                            state_q   <= ARB_IDLE;
                            grant_q   <= '0;
                            rr_last_q <= owner_q;
                            cnt_q     <= '0;
                            busy_q    <= 1'b0;
                            // A genuine last on the final permitted word is not an error.
                            if (!owner_last) burst_err_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: two 8-bit requesters, MAX_BURST=4.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  ack;
    logic [1:0]  grant;
    logic        fifo_full;
    logic        fifo_write_en;
    logic [7:0]  fifo_write_data;
    logic        busy;
    logic        burst_err;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_wr_arbiter #(
        .WIDTH     (8),
        .NREQ      (2),
        .MAX_BURST (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .req_data        (req_data),
        .req_last        (req_last),
        .ack             (ack),
        .grant           (grant),
        .fifo_full       (fifo_full),
        .fifo_write_en   (fifo_write_en),
        .fifo_write_data (fifo_write_data),
        .busy            (busy),
        .burst_err       (burst_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are then changed here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = 2'b00;
        req_last  = 2'b00;
        req_data  = 16'h0000;
        fifo_full = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req       = 2'b11;
        req_last  = 2'b11;
        req_data  = 16'hB0A0;
        fifo_full = 1'b0;
        cyc();
        @(negedge clk);
        n_checks++;
        if ({grant, busy, burst_err, fifo_write_en, ack} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_state: grant=%b busy=%b err=%b wen=%b ack=%b, expected all zero",
                     grant, busy, burst_err, fifo_write_en, ack);
        end
        rst = 1'b0;
        req = 2'b00;
        cyc();
    endtask

    task automatic test_single();
        do_reset();
        req      = 2'b01;
        req_last = 2'b01;
        req_data = 16'h0011;
        @(negedge clk);
        n_checks++;
        if ({grant, fifo_write_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL single_decide: grant=%b wen=%b, expected 00 0", grant, fifo_write_en);
        end
        cyc();
        @(negedge clk);
        n_checks++;
        if ({grant, fifo_write_en, fifo_write_data, ack, busy} !== {2'b01, 1'b1, 8'h11, 2'b01, 1'b1}) begin
            n_fail++;
            $display("FAIL single_write: grant=%b wen=%b data=%h ack=%b busy=%b, expected 01 1 11 01 1",
                     grant, fifo_write_en, fifo_write_data, ack, busy);
        end
        cyc();
        req = 2'b00;
        @(negedge clk);
        n_checks++;
        if ({grant, fifo_write_en, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_release: grant=%b wen=%b busy=%b, expected 00 0 0", grant, fifo_write_en, busy);
        end
        cyc();
    endtask

    task automatic test_alternate();
        logic       exp_wen;
        logic [1:0] exp_ack;
        logic [7:0] exp_data;
        do_reset();
        req      = 2'b11;
        req_last = 2'b11;
        req_data = 16'hB0A0;
        for (int k = 0; k < 8; k++) begin
            exp_wen  = (k % 2) == 1;
            exp_ack  = !exp_wen ? 2'b00 : ((k % 4) == 1) ? 2'b01 : 2'b10;
            exp_data = ((k % 4) == 1) ? 8'hA0 : 8'hB0;
            @(negedge clk);
            n_checks++;
            if ({fifo_write_en, ack, grant} !== {exp_wen, exp_ack, exp_ack}) begin
                n_fail++;
                $display("FAIL alt_cycle%0d: wen=%b ack=%b grant=%b, expected %b %b %b",
                         k, fifo_write_en, ack, grant, exp_wen, exp_ack, exp_ack);
            end
            if (exp_wen) begin
                n_checks++;
                if (fifo_write_data !== exp_data) begin
                    n_fail++;
                    $display("FAIL alt_data%0d: data=%h, expected %h", k, fifo_write_data, exp_data);
                end
            end
            cyc();
        end
        req = 2'b00;
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b00) begin
            n_fail++;
            $display("FAIL alt_idle: grant=%b, expected 00", grant);
        end
        cyc();
    endtask

    task automatic test_packet();
        logic [7:0] words [3];
        words[0] = 8'h01;
        words[1] = 8'h02;
        words[2] = 8'h03;
        do_reset();
        req      = 2'b11;
        req_last = 2'b10;
        req_data = {8'hB0, words[0]};
        @(negedge clk);
        cyc();
        for (int w = 0; w < 3; w++) begin
            req_data[7:0] = words[w];
            req_last[0]   = (w == 2);
            @(negedge clk);
            n_checks++;
            if ({fifo_write_en, fifo_write_data, ack, grant} !== {1'b1, words[w], 2'b01, 2'b01}) begin
                n_fail++;
                $display("FAIL pkt_word%0d: wen=%b data=%h ack=%b grant=%b, expected 1 %h 01 01",
                         w, fifo_write_en, fifo_write_data, ack, grant, words[w]);
            end
            cyc();
        end
        req = 2'b10;
        @(negedge clk);
        n_checks++;
        if ({grant, fifo_write_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL pkt_turnaround: grant=%b wen=%b, expected 00 0", grant, fifo_write_en);
        end
        cyc();
        @(negedge clk);
        n_checks++;
        if ({grant, fifo_write_en, fifo_write_data, ack} !== {2'b10, 1'b1, 8'hB0, 2'b10}) begin
            n_fail++;
            $display("FAIL pkt_next_owner: grant=%b wen=%b data=%h ack=%b, expected 10 1 b0 10",
                     grant, fifo_write_en, fifo_write_data, ack);
        end
        cyc();
        req = 2'b00;
        cyc();
    endtask

    task automatic test_full_stall();
        do_reset();
        req      = 2'b01;
        req_last = 2'b00;
        req_data = 16'h0031;
        @(negedge clk);
        cyc();
        @(negedge clk);
        n_checks++;
        if ({fifo_write_en, fifo_write_data, ack} !== {1'b1, 8'h31, 2'b01}) begin
            n_fail++;
            $display("FAIL full_first: wen=%b data=%h ack=%b, expected 1 31 01", fifo_write_en, fifo_write_data, ack);
        end
        cyc();
        req_data  = 16'h0032;
        fifo_full = 1'b1;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            n_checks++;
            if ({fifo_write_en, ack, grant, busy} !== {1'b0, 2'b00, 2'b01, 1'b1}) begin
                n_fail++;
                $display("FAIL full_stall%0d: wen=%b ack=%b grant=%b busy=%b, expected 0 00 01 1",
                         s, fifo_write_en, ack, grant, busy);
            end
            cyc();
        end
        fifo_full = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({fifo_write_en, fifo_write_data, ack} !== {1'b1, 8'h32, 2'b01}) begin
            n_fail++;
            $display("FAIL full_resume: wen=%b data=%h ack=%b, expected 1 32 01", fifo_write_en, fifo_write_data, ack);
        end
        cyc();
        req_data = 16'h0033;
        req_last = 2'b01;
        @(negedge clk);
        n_checks++;
        if ({fifo_write_en, fifo_write_data} !== {1'b1, 8'h33}) begin
            n_fail++;
            $display("FAIL full_last: wen=%b data=%h, expected 1 33", fifo_write_en, fifo_write_data);
        end
        cyc();
        req      = 2'b00;
        req_last = 2'b00;
        @(negedge clk);
        n_checks++;
        if ({grant, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL full_release: grant=%b busy=%b, expected 00 0", grant, busy);
        end
        cyc();
    endtask

    task automatic test_watchdog();
        do_reset();
        req      = 2'b10;
        req_last = 2'b00;
        req_data = 16'h5100;
        @(negedge clk);
        cyc();
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            n_checks++;
            if ({fifo_write_en, fifo_write_data, ack, burst_err} !== {1'b1, 8'(8'h51 + w), 2'b10, 1'b0}) begin
                n_fail++;
                $display("FAIL wd_word%0d: wen=%b data=%h ack=%b err=%b, expected 1 %h 10 0",
                         w, fifo_write_en, fifo_write_data, ack, burst_err, 8'(8'h51 + w));
            end
            cyc();
            req_data[15:8] = 8'(8'h52 + w);
        end
        @(negedge clk);
        n_checks++;
        if ({grant, fifo_write_en, busy, burst_err} !== {2'b00, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL wd_release: grant=%b wen=%b busy=%b err=%b, expected 00 0 0 1",
                     grant, fifo_write_en, busy, burst_err);
        end
        cyc();
        req_data[15:8] = 8'h60;
        req_last       = 2'b10;
        @(negedge clk);
        n_checks++;
        if ({grant, fifo_write_en, fifo_write_data, burst_err} !== {2'b10, 1'b1, 8'h60, 1'b1}) begin
            n_fail++;
            $display("FAIL wd_next_pkt: grant=%b wen=%b data=%h err=%b, expected 10 1 60 1",
                     grant, fifo_write_en, fifo_write_data, burst_err);
        end
        cyc();
        req      = 2'b00;
        req_last = 2'b00;
        @(negedge clk);
        n_checks++;
        if ({grant, burst_err} !== 3'b001) begin
            n_fail++;
            $display("FAIL wd_sticky: grant=%b err=%b, expected 00 1", grant, burst_err);
        end
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (burst_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_clear: err=%b, expected 0", burst_err);
        end
        cyc();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req      = 2'b11;
        req_last = 2'b00;
        req_data = 16'hB171;
        @(negedge clk);
        cyc();
        @(negedge clk);
        n_checks++;
        if ({fifo_write_en, fifo_write_data, ack} !== {1'b1, 8'h71, 2'b01}) begin
            n_fail++;
            $display("FAIL rstmid_word1: wen=%b data=%h ack=%b, expected 1 71 01", fifo_write_en, fifo_write_data, ack);
        end
        cyc();
        req_data[7:0] = 8'h72;
        rst           = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({fifo_write_en, ack} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstmid_gate: wen=%b ack=%b, expected 0 00", fifo_write_en, ack);
        end
        cyc();
        rst      = 1'b0;
        req_last = 2'b11;
        @(negedge clk);
        n_checks++;
        if ({grant, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstmid_cleared: grant=%b busy=%b, expected 00 0", grant, busy);
        end
        cyc();
        @(negedge clk);
        n_checks++;
        if ({grant, fifo_write_en, fifo_write_data, ack} !== {2'b01, 1'b1, 8'h72, 2'b01}) begin
            n_fail++;
            $display("FAIL rstmid_rearb: grant=%b wen=%b data=%h ack=%b, expected 01 1 72 01",
                     grant, fifo_write_en, fifo_write_data, ack);
        end
        cyc();
        req = 2'b00;
        cyc();
    endtask

    initial begin
        rst       = 1'b1;
        req       = 2'b00;
        req_last  = 2'b00;
        req_data  = 16'h0000;
        fifo_full = 1'b0;
        #1;
        test_reset();
        test_single();
        test_alternate();
        test_packet();
        test_full_stall();
        test_watchdog();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
